// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit.
// Imported by pc_ras and pc_unit.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_REDIR,
        SEL_CALL,
        SEL_RET,
        SEL_CALLRET
    } next_pc_sel_e;

    localparam int RAS_DEPTH_DEF = 4;
    localparam int PTR_W         = $clog2(RAS_DEPTH_DEF);

    function automatic longint unsigned align_mask(
        input longint unsigned bytes
    );
        return bytes - 64'd1;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full drops the oldest entry.
// Replace overwrites the top in place, or pushes if the stack is empty.
module pc_ras
    import pc_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_replace,
    input  logic [XLEN-1:0] i_din,
    output logic [XLEN-1:0] o_top,
    output logic            o_empty,
    output logic            o_full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   w_ptr_inc;
    logic            w_do_push;

    assign w_ptr_inc = r_ptr + 1'b1;
    assign o_top     = r_mem[r_ptr];
    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == CW'(RAS_DEPTH));
    assign w_do_push = i_push || (i_replace && o_empty);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
            r_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[w_ptr_inc] <= i_din;
            r_ptr            <= w_ptr_inc;
            if (!o_full) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (i_replace) begin
            r_mem[r_ptr] <= i_din;
        end else if (i_pop && !o_empty) begin
            r_ptr <= r_ptr - 1'b1;
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC priority mux, CIS register and flags.
// Return addresses are predicted by the pc_ras stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int              INSTR_BYTES = 4,
    parameter int              RAS_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pcWrite,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            call,
    input  logic [XLEN-1:0] call_target,
    input  logic            ret,
    output logic [XLEN-1:0] CIS,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            misaligned,
    output logic            ras_underflow
);

    localparam logic [XLEN-1:0] LOW_MASK =
        XLEN'(align_mask(64'(INSTR_BYTES)));

    logic [XLEN-1:0] r_cis;
    logic            r_mis;
    logic            r_uf;
    logic [XLEN-1:0] w_seq;
    logic [XLEN-1:0] w_next;
    logic [XLEN-1:0] w_top;
    logic            w_empty;
    logic            w_full;
    logic            w_uf;
    next_pc_sel_e    w_sel;

    assign w_seq = r_cis + XLEN'(INSTR_BYTES);

    always_comb begin
        w_sel = SEL_SEQ;
        if (redirect) begin
            w_sel = SEL_REDIR;
        end else if (call && ret) begin
            w_sel = SEL_CALLRET;
        end else if (call) begin
            w_sel = SEL_CALL;
        end else if (ret && !w_empty) begin
            w_sel = SEL_RET;
        end
    end

    always_comb begin
        case (w_sel)
            SEL_REDIR:   w_next = redirect_target;
            SEL_CALL:    w_next = call_target;
            SEL_CALLRET: w_next = call_target;
            SEL_RET:     w_next = w_top;
            default:     w_next = w_seq;
        endcase
    end

    // A return with nothing predicted falls through sequentially.
    assign w_uf = ret && !redirect && !call && w_empty;

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .i_push    (pcWrite && (w_sel == SEL_CALL)),
        .i_pop     (pcWrite && (w_sel == SEL_RET)),
        .i_replace (pcWrite && (w_sel == SEL_CALLRET)),
        .i_din     (w_seq),
        .o_top     (w_top),
        .o_empty   (w_empty),
        .o_full    (w_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cis <= RESET_VEC;
            r_mis <= 1'b0;
            r_uf  <= 1'b0;
        end else if (pcWrite) begin
            r_cis <= w_next;
            r_mis <= |(w_next & LOW_MASK);
            r_uf  <= w_uf;
        end else begin
            r_uf  <= 1'b0;
        end
    end

    assign CIS           = r_cis;
    assign misaligned    = r_mis;
    assign ras_underflow = r_uf;
    assign ras_empty     = w_empty;
    assign ras_full      = w_full;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, async-reset sequence,
// then random stimulus against a queue-based reference model.
module tb_pc_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pcWrite = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        call = 1'b0;
    logic [31:0] call_target = '0;
    logic        ret = 1'b0;
    logic [31:0] CIS;
    logic        ras_empty;
    logic        ras_full;
    logic        misaligned;
    logic        ras_underflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_unit #(
        .XLEN        (32),
        .RESET_VEC   (32'h0),
        .INSTR_BYTES (4),
        .RAS_DEPTH   (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pcWrite         (pcWrite),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .call            (call),
        .call_target     (call_target),
        .ret             (ret),
        .CIS             (CIS),
        .ras_empty       (ras_empty),
        .ras_full        (ras_full),
        .misaligned      (misaligned),
        .ras_underflow   (ras_underflow)
    );

    typedef struct {
        logic        pcw;
        logic        redir;
        logic [31:0] rt;
        logic        call;
        logic [31:0] ct;
        logic        ret;
        logic [31:0] cis;
        logic        emp;
        logic        ful;
        logic        uf;
        logic        mis;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic addv(input logic pcw, input logic rd, input logic [31:0] rt,
                        input logic c, input logic [31:0] ct, input logic r,
                        input logic [31:0] cis, input logic emp,
                        input logic ful, input logic uf, input logic mis);
        vec_t v;
        v.pcw = pcw; v.redir = rd; v.rt = rt; v.call = c; v.ct = ct;
        v.ret = r; v.cis = cis; v.emp = emp; v.ful = ful; v.uf = uf;
        v.mis = mis;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic pcw, input logic rd, input logic [31:0] rt,
                         input logic c, input logic [31:0] ct, input logic r);
        pcWrite = pcw; redirect = rd; redirect_target = rt;
        call = c; call_target = ct; ret = r;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] cis,
                           input logic emp, input logic ful,
                           input logic uf, input logic mis);
        chk({tag, ".CIS"}, CIS, cis);
        chk({tag, ".empty"}, 32'(ras_empty), 32'(emp));
        chk({tag, ".full"}, 32'(ras_full), 32'(ful));
        chk({tag, ".underflow"}, 32'(ras_underflow), 32'(uf));
        chk({tag, ".misaligned"}, 32'(misaligned), 32'(mis));
    endtask

    // Reference model: architectural PC plus a bounded list of return
    // addresses, newest at the back.
    logic [31:0] m_cis;
    logic [31:0] m_q[$];
    logic        m_mis;
    logic        m_uf;

    task automatic model_step(input logic pcw, input logic rd,
                              input logic [31:0] rt, input logic c,
                              input logic [31:0] ct, input logic r);
        logic [31:0] seq;
        logic [31:0] nxt;
        if (!pcw) begin
            m_uf = 1'b0;
            return;
        end
        seq  = m_cis + 32'd4;
        m_uf = 1'b0;
        if (rd) begin
            nxt = rt;
        end else if (c && r) begin
            nxt = ct;
            if (m_q.size() == 0) m_q.push_back(seq);
            else m_q[m_q.size() - 1] = seq;
        end else if (c) begin
            nxt = ct;
            if (m_q.size() == DEPTH) void'(m_q.pop_front());
            m_q.push_back(seq);
        end else if (r) begin
            if (m_q.size() > 0) begin
                nxt = m_q.pop_back();
            end else begin
                nxt  = seq;
                m_uf = 1'b1;
            end
        end else begin
            nxt = seq;
        end
        m_cis = nxt;
        m_mis = (nxt % 4) != 0;
    endtask

    initial begin
        // Sequential advance and redirect to 0x10
        addv(1,0,0,0,0,0, 32'h4, 1,0,0,0);
        addv(1,0,0,0,0,0, 32'h8, 1,0,0,0);
        addv(1,0,0,0,0,0, 32'hC, 1,0,0,0);
        addv(1,1,32'h10,0,0,0, 32'h10, 1,0,0,0);
        // Stall with call asserted
        addv(0,0,0,1,32'h500,0, 32'h10, 1,0,0,0);
        addv(0,0,0,1,32'h500,0, 32'h10, 1,0,0,0);
        addv(1,0,0,0,0,0, 32'h14, 1,0,0,0);
        // Call / return
        addv(1,1,32'h100,0,0,0, 32'h100, 1,0,0,0);
        addv(1,0,0,1,32'h400,0, 32'h400, 0,0,0,0);
        addv(1,0,0,0,0,1, 32'h104, 1,0,0,0);
        // Overflow then underflow
        addv(1,1,32'h0,0,0,0, 32'h0, 1,0,0,0);
        addv(1,0,0,1,32'h10,0, 32'h10, 0,0,0,0);
        addv(1,0,0,1,32'h20,0, 32'h20, 0,0,0,0);
        addv(1,0,0,1,32'h30,0, 32'h30, 0,0,0,0);
        addv(1,0,0,1,32'h40,0, 32'h40, 0,1,0,0);
        addv(1,0,0,1,32'h1000,0, 32'h1000, 0,1,0,0);
        addv(1,0,0,0,0,1, 32'h44, 0,0,0,0);
        addv(1,0,0,0,0,1, 32'h34, 0,0,0,0);
        addv(1,0,0,0,0,1, 32'h24, 0,0,0,0);
        addv(1,0,0,0,0,1, 32'h14, 1,0,0,0);
        addv(1,0,0,0,0,1, 32'h18, 1,0,1,0);
        addv(1,0,0,0,0,0, 32'h1C, 1,0,0,0);
        // Priority: redirect over call+ret, then call+ret replaces top
        addv(1,0,0,1,32'h200,0, 32'h200, 0,0,0,0);
        addv(1,1,32'h800,1,32'h900,1, 32'h800, 0,0,0,0);
        addv(1,0,0,1,32'h900,1, 32'h900, 0,0,0,0);
        addv(1,0,0,0,0,1, 32'h804, 1,0,0,0);
        // Wrap and misalignment
        addv(1,1,32'hFFFFFFFC,0,0,0, 32'hFFFFFFFC, 1,0,0,0);
        addv(1,0,0,0,0,0, 32'h0, 1,0,0,0);
        addv(1,1,32'h202,0,0,0, 32'h202, 1,0,0,1);
        addv(1,0,0,0,0,0, 32'h206, 1,0,0,1);
        addv(0,1,32'h300,0,0,0, 32'h206, 1,0,0,1);
        addv(1,1,32'h300,0,0,0, 32'h300, 1,0,0,0);
        // Call+ret on empty stack acts as push
        addv(1,0,0,1,32'h600,1, 32'h600, 0,0,0,0);
        addv(1,0,0,0,0,1, 32'h304, 1,0,0,0);
        // Underflow pulse is cleared by a stall
        addv(0,0,0,0,0,1, 32'h304, 1,0,0,0);
        addv(1,0,0,0,0,1, 32'h308, 1,0,1,0);
        addv(0,0,0,0,0,0, 32'h308, 1,0,0,0);

        #1 reset = 1'b1;
        #2;
        chk_all("reset", 32'h0, 1, 0, 0, 0);
        @(posedge clk);
        #2 reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].pcw, vecs[i].redir, vecs[i].rt,
                  vecs[i].call, vecs[i].ct, vecs[i].ret);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].cis, vecs[i].emp,
                    vecs[i].ful, vecs[i].uf, vecs[i].mis);
        end

        // Asynchronous reset mid-cycle with entries on the stack
        drive(1,0,0,1,32'h700,0);
        @(posedge clk);
        drive(1,0,0,1,32'h780,0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk_all("async_rst", 32'h0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("rst_held", 32'h0, 1, 0, 0, 0);
        #2 reset = 1'b0;
        drive(1,0,0,0,0,1);
        @(posedge clk);
        #1;
        chk_all("post_rst", 32'h4, 1, 0, 1, 0);

        m_cis = 32'h4;
        m_q.delete();
        m_mis = 1'b0;
        m_uf  = 1'b1;

        for (int n = 0; n < 400; n++) begin
            logic        pcw, rd, c, r;
            logic [31:0] rt, ct;
            pcw = ($urandom_range(0, 9) < 8);
            rd  = ($urandom_range(0, 9) < 1);
            c   = ($urandom_range(0, 9) < 3);
            r   = ($urandom_range(0, 9) < 3);
            rt  = $urandom;
            ct  = $urandom;
            if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) ct[1:0] = 2'b00;
            drive(pcw, rd, rt, c, ct, r);
            model_step(pcw, rd, rt, c, ct, r);
            @(posedge clk);
            #1;
            chk_all($sformatf("rnd%0d", n), m_cis, m_q.size() == 0,
                    m_q.size() == DEPTH, m_uf, m_mis);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
